npu_load_sequencer: RTL and testbench
=====================================

NPU_LOAD_SEQUENCER -- requirements
Module: npu_load_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- IMG_WORDS, 224, 32-bit image words per load
- CONV_BYTES, 18816, conv weight bytes
- DENSE_BYTES, 16746, dense weight bytes
- BIAS_BYTES, 10, dense bias bytes
REQ-002 Ports SHALL be, one per line:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse; begins a load sequence
- abort  in  1  pulse; cancels the sequence in progress
- wr_valid  in  1  host data valid
- wr_data  in  32  host data
- wr_ready  out  1  sequencer accepts wr_data
- img_we  out  4  write enable per image bank 0..3
- img_addr  out  8  image word address
- img_data  out  32  bank n receives byte [31-8n:24-8n]
- conv_we / dense_we / bias_we  out  1 each  weight RAM write enables
- conv_addr / dense_addr  out  15 each  byte addresses
- bias_addr  out  4  bias byte address
- wgt_data  out  8  byte shared by conv, dense and bias RAMs
- busy  out  1  high in any LOAD_* state
- done  out  1  sticky; sequence completed
- err  out  1  sticky; start received while busy
- phase  out  3  current state encoding

Function
REQ-003 FSM states SHALL be IDLE(0), LOAD_IMG(1), LOAD_CONV(2), LOAD_DENSE(3), LOAD_BIAS(4), and phase SHALL equal the state code.
REQ-004 A transfer SHALL occur on every cycle with wr_valid && wr_ready; wr_ready SHALL be high in LOAD_* states, except as REQ-013 states, and low in IDLE.
REQ-005 A start in IDLE SHALL enter LOAD_IMG, clear done and err, and zero all element counters and addresses.
REQ-006 Each LOAD_IMG transfer SHALL produce, one cycle later, img_we=4'b1111, img_addr=word index and img_data=wr_data.
REQ-007 Each LOAD_CONV/LOAD_DENSE/LOAD_BIAS transfer SHALL produce, one cycle later, a single-cycle write with wgt_data=wr_data[7:0], the matching _we high and its address set to the byte index.
REQ-008 The state SHALL advance LOAD_IMG -> LOAD_CONV -> LOAD_DENSE -> LOAD_BIAS -> IDLE on the cycle after the transfer of the last element (IMG_WORDS-1, CONV_BYTES-1, DENSE_BYTES-1, BIAS_BYTES-1); no extra transfer SHALL be accepted in between.
REQ-009 On leaving LOAD_BIAS, done SHALL be set and held until the next accepted start or reset.
REQ-010 All write enables SHALL be low in cycles with no pending write; at most one of img_we, conv_we, dense_we and bias_we SHALL be nonzero in any cycle.
REQ-011 A start while busy SHALL be ignored and SHALL set err; a start and abort in the same cycle SHALL be treated as abort only.
REQ-012 An abort while busy SHALL return to IDLE on the next cycle, squash any pending write so that no _we is asserted, and leave done=0; an abort in IDLE SHALL have no effect.

Reset
REQ-014 Reset SHALL force IDLE with wr_ready=0, every _we=0, all addresses and counters 0, wgt_data=0, img_data=0, and busy, done and err all 0, and it SHALL take priority over start and abort in the same cycle.
REQ-015 Reset mid-sequence SHALL discard all progress; no write SHALL be issued in the cycle after reset.

Configuration
REQ-013 With PACK4_WGT_EN defined:
- weight phases SHALL unpack each transfer into up to 4 byte writes on consecutive cycles, order [7:0], [15:8], [23:16], [31:24]
- wr_ready SHALL be low during the remaining 3 unpack cycles
- bytes past the phase's last element SHALL be discarded; e.g. the final DENSE word writes 2 bytes
- the next phase SHALL begin with a fresh word
Without PACK4_WGT_EN, weight phases SHALL consume one byte per transfer per REQ-007.

Verification
REQ-016 Bench SHALL cover:
- Full load, wr_valid held high: start, then 224 + 18816 + 16746 + 10 transfers -> phase steps 1,2,3,4,0; done=1; last addresses img 223, conv 18815, dense 16745, bias 9.
- Image write: wr_data=32'hAABBCCDD at word 5 -> next cycle img_we=4'hF, img_addr=5, img_data=32'hAABBCCDD.
- Backpressure: wr_valid toggled every other cycle -> addresses advance only on transfers, with no duplicate or skipped write.
- Abort at conv byte 100 -> IDLE next cycle, no _we asserted afterwards, done=0; a new start restarts at img_addr 0.
- Start during LOAD_DENSE -> err=1, sequence continues unaffected; reset mid-LOAD_CONV -> all outputs at reset values.
- PACK4_WGT_EN build: last dense word 32'h44332211 -> dense writes 8'h11 at 16744 and 8'h22 at 16745, then phase=4.

Source files
------------

// File: rtl/npu_load_sequencer.sv
// npu_load_sequencer: streams host words into four image banks, then conv, dense and bias weight RAMs.
// Optional build macro PACK4_WGT_EN: weight phases unpack up to four bytes from each host word.
module npu_load_sequencer #(
  parameter int IMG_WORDS   = 224,
  parameter int CONV_BYTES  = 18816,
  parameter int DENSE_BYTES = 16746,
  parameter int BIAS_BYTES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic [3:0]  img_we,
  output logic [7:0]  img_addr,
  output logic [31:0] img_data,
  output logic        conv_we,
  output logic        dense_we,
  output logic        bias_we,
  output logic [14:0] conv_addr,
  output logic [14:0] dense_addr,
  output logic [3:0]  bias_addr,
  output logic [7:0]  wgt_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  phase
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_IMG   = 3'd1,
    S_CONV  = 3'd2,
    S_DENSE = 3'd3,
    S_BIAS  = 3'd4
  } state_e;

  localparam logic [14:0] IMG_LAST   = 15'(IMG_WORDS - 1);
  localparam logic [14:0] CONV_LAST  = 15'(CONV_BYTES - 1);
  localparam logic [14:0] DENSE_LAST = 15'(DENSE_BYTES - 1);
  localparam logic [14:0] BIAS_LAST  = 15'(BIAS_BYTES - 1);

  state_e      state_q, state_d;
  logic [14:0] cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [3:0]  img_we_q, img_we_d;
  logic [7:0]  img_addr_q, img_addr_d;
  logic [31:0] img_data_q, img_data_d;
  logic        conv_we_q, conv_we_d;
  logic        dense_we_q, dense_we_d;
  logic        bias_we_q, bias_we_d;
  logic [14:0] conv_addr_q, conv_addr_d;
  logic [14:0] dense_addr_q, dense_addr_d;
  logic [3:0]  bias_addr_q, bias_addr_d;
  logic [7:0]  wgt_data_q, wgt_data_d;

  logic        xfer_s, step_s, abort_s, start_ok_s, start_err_s;
  logic        unpack_s, wgt_phase_s, last_hit_s;
  logic [14:0] last_s;
  logic [7:0]  byte_s;

  assign busy        = (state_q != S_IDLE);
  assign wr_ready    = busy && !unpack_s;
  assign phase       = state_q;
  assign xfer_s      = wr_valid && wr_ready;
  assign step_s      = xfer_s || unpack_s;
  assign abort_s     = abort && busy;
  assign start_ok_s  = start && !abort && !busy;
  assign start_err_s = start && !abort && busy;
  assign wgt_phase_s = (state_q == S_CONV) || (state_q == S_DENSE) || (state_q == S_BIAS);
  assign last_hit_s  = step_s && (cnt_q == last_s);

`ifdef PACK4_WGT_EN
  logic [31:0] word_q, word_d;
  logic [1:0]  sub_q, sub_d;
  logic        unpack_q, unpack_d;

  assign unpack_s = unpack_q;
  assign byte_s   = unpack_q ? word_q[{sub_q, 3'b000} +: 8] : wr_data[7:0];

  // Unpack bookkeeping: a word is captured on transfer, its upper bytes go out on the following cycles.
  always_comb begin
    word_d   = word_q;
    sub_d    = sub_q;
    unpack_d = unpack_q;
    if (abort_s || start_ok_s || last_hit_s) begin
      unpack_d = 1'b0;
      sub_d    = 2'd0;
    end else if (xfer_s && wgt_phase_s) begin
      word_d   = wr_data;
      sub_d    = 2'd1;
      unpack_d = 1'b1;
    end else if (unpack_q) begin
      sub_d    = sub_q + 2'd1;
      unpack_d = (sub_q != 2'd3);
    end else begin
      unpack_d = 1'b0;
    end
  end

  // Unpack registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q   <= 32'd0;
      sub_q    <= 2'd0;
      unpack_q <= 1'b0;
    end else begin
      word_q   <= word_d;
      sub_q    <= sub_d;
      unpack_q <= unpack_d;
    end
  end
`else
  assign unpack_s = 1'b0;
  assign byte_s   = wr_data[7:0];
`endif

  // Last element index of the current phase.
  always_comb begin
    case (state_q)
      S_IMG:   last_s = IMG_LAST;
      S_CONV:  last_s = CONV_LAST;
      S_DENSE: last_s = DENSE_LAST;
      S_BIAS:  last_s = BIAS_LAST;
      default: last_s = 15'd0;
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 15'd0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      img_we_q     <= 4'd0;
      img_addr_q   <= 8'd0;
      img_data_q   <= 32'd0;
      conv_we_q    <= 1'b0;
      dense_we_q   <= 1'b0;
      bias_we_q    <= 1'b0;
      conv_addr_q  <= 15'd0;
      dense_addr_q <= 15'd0;
      bias_addr_q  <= 4'd0;
      wgt_data_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      err_q        <= err_d;
      img_we_q     <= img_we_d;
      img_addr_q   <= img_addr_d;
      img_data_q   <= img_data_d;
      conv_we_q    <= conv_we_d;
      dense_we_q   <= dense_we_d;
      bias_we_q    <= bias_we_d;
      conv_addr_q  <= conv_addr_d;
      dense_addr_q <= dense_addr_d;
      bias_addr_q  <= bias_addr_d;
      wgt_data_q   <= wgt_data_d;
    end
  end

  // Next state: abort beats start, and a start while busy only flags err.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    if (abort_s) begin
      state_d = S_IDLE;
      cnt_d   = 15'd0;
    end else if (start_ok_s) begin
      state_d = S_IMG;
      cnt_d   = 15'd0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (start_err_s) err_d = 1'b1;
      else             err_d = err_q;
      if (last_hit_s) begin
        cnt_d = 15'd0;
        case (state_q)
          S_IMG:   state_d = S_CONV;
          S_CONV:  state_d = S_DENSE;
          S_DENSE: state_d = S_BIAS;
          S_BIAS: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end else if (step_s) begin
        cnt_d = cnt_q + 15'd1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // Output path: one element written per step, squashed by abort; addresses hold between writes.
  always_comb begin
    img_we_d     = 4'd0;
    conv_we_d    = 1'b0;
    dense_we_d   = 1'b0;
    bias_we_d    = 1'b0;
    img_addr_d   = img_addr_q;
    img_data_d   = img_data_q;
    conv_addr_d  = conv_addr_q;
    dense_addr_d = dense_addr_q;
    bias_addr_d  = bias_addr_q;
    wgt_data_d   = wgt_data_q;
    if (start_ok_s) begin
      img_addr_d   = 8'd0;
      conv_addr_d  = 15'd0;
      dense_addr_d = 15'd0;
      bias_addr_d  = 4'd0;
    end else if (step_s && !abort_s) begin
      case (state_q)
        S_IMG: begin
          img_we_d   = 4'b1111;
          img_addr_d = cnt_q[7:0];
          img_data_d = wr_data;
        end
        S_CONV: begin
          conv_we_d   = 1'b1;
          conv_addr_d = cnt_q;
          wgt_data_d  = byte_s;
        end
        S_DENSE: begin
          dense_we_d   = 1'b1;
          dense_addr_d = cnt_q;
          wgt_data_d   = byte_s;
        end
        S_BIAS: begin
          bias_we_d   = 1'b1;
          bias_addr_d = cnt_q[3:0];
          wgt_data_d  = byte_s;
        end
        default: img_we_d = 4'd0;
      endcase
    end else begin
      img_we_d = 4'd0;
    end
  end

  assign img_we     = img_we_q;
  assign img_addr   = img_addr_q;
  assign img_data   = img_data_q;
  assign conv_we    = conv_we_q;
  assign dense_we   = dense_we_q;
  assign bias_we    = bias_we_q;
  assign conv_addr  = conv_addr_q;
  assign dense_addr = dense_addr_q;
  assign bias_addr  = bias_addr_q;
  assign wgt_data   = wgt_data_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_npu_load_sequencer.sv
// Scoreboard bench for npu_load_sequencer: a cycle model pushes expected writes, a monitor pops and compares them.
// Also builds with PACK4_WGT_EN defined.
module tb_npu_load_sequencer;

  localparam int IMG_WORDS   = 224;
  localparam int CONV_BYTES  = 18816;
  localparam int DENSE_BYTES = 16746;
  localparam int BIAS_BYTES  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ready;
  logic [3:0]  img_we;
  logic [7:0]  img_addr;
  logic [31:0] img_data;
  logic        conv_we, dense_we, bias_we;
  logic [14:0] conv_addr, dense_addr;
  logic [3:0]  bias_addr;
  logic [7:0]  wgt_data;
  logic        busy, done, err;
  logic [2:0]  phase;

  npu_load_sequencer #(
    .IMG_WORDS(IMG_WORDS), .CONV_BYTES(CONV_BYTES),
    .DENSE_BYTES(DENSE_BYTES), .BIAS_BYTES(BIAS_BYTES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .img_we(img_we), .img_addr(img_addr), .img_data(img_data),
    .conv_we(conv_we), .dense_we(dense_we), .bias_we(bias_we),
    .conv_addr(conv_addr), .dense_addr(dense_addr), .bias_addr(bias_addr),
    .wgt_data(wgt_data), .busy(busy), .done(done), .err(err), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  logic mon_en = 1'b0;

  // reference model state
  int          m_state = 0;
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic        m_unpack = 1'b0;
  int          m_sub = 0;
  logic [31:0] m_word = 32'd0;

  function automatic int last_of(input int s);
    case (s)
      1: return IMG_WORDS - 1;
      2: return CONV_BYTES - 1;
      3: return DENSE_BYTES - 1;
      4: return BIAS_BYTES - 1;
      default: return 0;
    endcase
  endfunction

  function automatic void push(input int k, input int a, input logic [31:0] d);
    wr_t w;
    w.kind = k;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endfunction

  // Advance the model by one clock given the inputs applied this cycle.
  function automatic void model_step(input logic xfer, input logic [31:0] d,
                                     input logic st, input logic ab, input logic rs);
    logic        bsy;
    logic [7:0]  b;
    bsy = (m_state != 0);
    if (rs) begin
      m_state = 0; m_cnt = 0; m_done = 1'b0; m_err = 1'b0; m_unpack = 1'b0; m_sub = 0;
    end else if (ab && bsy) begin
      m_state = 0; m_cnt = 0; m_unpack = 1'b0; m_sub = 0;
    end else if (st && !ab && !bsy) begin
      m_state = 1; m_cnt = 0; m_done = 1'b0; m_err = 1'b0; m_unpack = 1'b0; m_sub = 0;
    end else begin
      if (st && !ab && bsy) m_err = 1'b1;
      if (xfer || m_unpack) begin
        b = m_unpack ? m_word[8*m_sub +: 8] : d[7:0];
        if (m_state == 1) push(0, m_cnt, d);
        else              push(m_state - 1, m_cnt, {24'd0, b});
        if (m_cnt == last_of(m_state)) begin
          if (m_state == 4) m_done = 1'b1;
          m_state  = (m_state == 4) ? 0 : m_state + 1;
          m_cnt    = 0;
          m_unpack = 1'b0;
          m_sub    = 0;
        end else begin
          m_cnt = m_cnt + 1;
`ifdef PACK4_WGT_EN
          if (xfer && m_state >= 2) begin
            m_unpack = 1'b1; m_sub = 1; m_word = d;
          end else if (m_unpack) begin
            if (m_sub == 3) m_unpack = 1'b0;
            m_sub = m_sub + 1;
          end
`endif
        end
      end
    end
  endfunction

  // One cycle: check status against the model, apply inputs, step the model, wait for the next negedge.
  task automatic drive(input logic v, input logic [31:0] d, input logic st,
                       input logic ab, input logic rs);
    logic       rdy;
    logic [6:0] exp_st;
    rdy    = (m_state != 0) && !m_unpack;
    exp_st = {3'(m_state), (m_state != 0), rdy, m_done, m_err};
    vectors++;
    if ({phase, busy, wr_ready, done, err} !== exp_st) begin
      miscompares++;
      $display("FAIL status phase/busy/ready/done/err: got %b expected %b (t=%0t)",
               {phase, busy, wr_ready, done, err}, exp_st, $time);
    end
    wr_valid = v; wr_data = d; start = st; abort = ab; reset = rs;
    model_step(v && rdy && !rs, d, st, ab, rs);
    @(negedge clk);
  endtask

  // Write monitor: each observed write must match the head of the scoreboard.
  always @(negedge clk) begin
    int          nwe;
    int          ok_kind, ok_addr;
    logic [31:0] ok_data;
    wr_t         e;
    if (mon_en) begin
      nwe = int'(img_we != 4'd0) + int'(conv_we) + int'(dense_we) + int'(bias_we);
      if (nwe != 0) begin
        vectors++;
        if (img_we != 4'd0)  begin ok_kind = 0; ok_addr = int'(img_addr);   ok_data = img_data; end
        else if (conv_we)    begin ok_kind = 1; ok_addr = int'(conv_addr);  ok_data = {24'd0, wgt_data}; end
        else if (dense_we)   begin ok_kind = 2; ok_addr = int'(dense_addr); ok_data = {24'd0, wgt_data}; end
        else                 begin ok_kind = 3; ok_addr = int'(bias_addr);  ok_data = {24'd0, wgt_data}; end
        if (nwe > 1) begin
          miscompares++;
          $display("FAIL multiple_we: img_we=%h conv=%b dense=%b bias=%b, required at most one", img_we, conv_we, dense_we, bias_we);
        end else if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_write: kind=%0d addr=%0d data=%h, none expected (t=%0t)", ok_kind, ok_addr, ok_data, $time);
        end else begin
          e = exp_q.pop_front();
          if (ok_kind != e.kind || ok_addr != e.addr || ok_data !== e.data ||
              (ok_kind == 0 && img_we !== 4'hF)) begin
            miscompares++;
            $display("FAIL write: got kind=%0d addr=%0d data=%h img_we=%h, expected kind=%0d addr=%0d data=%h",
                     ok_kind, ok_addr, ok_data, img_we, e.kind, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic test_reset();
    drive(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    vectors++;
    if ({wr_ready, img_we, img_addr, img_data, conv_we, dense_we, bias_we, conv_addr, dense_addr,
         bias_addr, wgt_data, busy, done, err, phase} !== 104'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: some output nonzero (phase=%0d busy=%b ready=%b), required all 0", phase, busy, wr_ready);
    end
  endtask

  task automatic test_img_write();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hAABBCCDD, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (img_we !== 4'hF || img_addr !== 8'd5 || img_data !== 32'hAABBCCDD) begin
      miscompares++;
      $display("FAIL img_write: got we=%h addr=%0d data=%h, expected F 5 AABBCCDD", img_we, img_addr, img_data);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) drive((i % 2) == 0, $urandom, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (img_addr !== 8'd31) begin
      miscompares++;
      $display("FAIL backpressure_addr: got img_addr=%0d, expected 31", img_addr);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    int guard = 0;
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    while (!(m_state == 2 && m_cnt == 100) && guard < 2000) begin
      drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    vectors++;
    if (guard >= 2000) begin
      miscompares++;
      $display("FAIL abort_reach: model never reached conv byte 100, got cycles=%0d", guard);
    end
    drive(1'b1, $urandom, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (done !== 1'b0 || phase !== 3'd0 || conv_addr !== 15'd99) begin
      miscompares++;
      $display("FAIL abort_state: got done=%b phase=%0d conv_addr=%0d, expected 0 0 99", done, phase, conv_addr);
    end
    drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    vectors++;
    if ({img_addr, conv_addr, dense_addr, bias_addr} !== 42'd0) begin
      miscompares++;
      $display("FAIL restart_addr: got img=%0d conv=%0d dense=%0d bias=%0d, expected all 0", img_addr, conv_addr, dense_addr, bias_addr);
    end
    for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int guard = 0;
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    while (!(m_state == 3 && m_cnt == 50) && guard < 30000) begin
      drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    drive(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (err !== 1'b1 || phase !== 3'd3) begin
      miscompares++;
      $display("FAIL start_while_busy: got err=%b phase=%0d, expected 1 3", err, phase);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_conv();
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < IMG_WORDS + 60; i++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    drive(1'b1, $urandom, 1'b1, 1'b1, 1'b1);
    vectors++;
    if ({wr_ready, img_we, img_addr, img_data, conv_we, dense_we, bias_we, conv_addr, dense_addr,
         bias_addr, wgt_data, busy, done, err, phase} !== 104'd0) begin
      miscompares++;
      $display("FAIL reset_mid_conv: got phase=%0d conv_addr=%0d conv_we=%b wgt=%h, expected all outputs 0", phase, conv_addr, conv_we, wgt_data);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_full_load();
    int          guard = 0;
    logic [31:0] d;
    drive(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    while (m_state != 0 && guard < 60000) begin
      d = (m_state == 3 && m_cnt == DENSE_BYTES - 2) ? 32'h44332211 : $urandom;
      drive(1'b1, d, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    vectors++;
    if (guard >= 60000) begin
      miscompares++;
      $display("FAIL full_load_timeout: got %0d cycles without completion", guard);
    end
    for (int i = 0; i < 2; i++) drive(1'b1, $urandom, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (done !== 1'b1 || phase !== 3'd0 || img_addr !== 8'd223 || conv_addr !== 15'd18815 ||
        dense_addr !== 15'd16745 || bias_addr !== 4'd9) begin
      miscompares++;
      $display("FAIL full_load_end: got done=%b phase=%0d img=%0d conv=%0d dense=%0d bias=%0d, expected 1 0 223 18815 16745 9",
               done, phase, img_addr, conv_addr, dense_addr, bias_addr);
    end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    test_reset();
    test_img_write();
    test_backpressure();
    test_abort();
    test_start_while_busy();
    test_reset_mid_conv();
    test_full_load();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d writes never seen, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
